// File: rtl/display_scan.sv
// Four-digit time-multiplexed scan controller for a common-anode seven-segment display.
// Digit values and enables are latched once per frame so a whole frame draws from one snapshot.
module display_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_digits_in,
  input  logic [3:0] i_digit_en,
  output logic [1:0] o_value,
  output logic [3:0] o_anodes,
  output logic       o_frame_tick
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [7:0]    r_val_sh;
  logic [3:0]    r_en_sh;
  logic          r_frame_tick;

  logic          w_blank;
  logic [3:0]    w_onehot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_val_sh     <= 8'd0;
      r_en_sh      <= 4'd0;
      r_frame_tick <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        // frame boundary: snapshot inputs for the frame that starts next cycle
        r_val_sh     <= i_digits_in;
        r_en_sh      <= i_digit_en;
        r_frame_tick <= 1'b1;
      end else begin
        r_frame_tick <= 1'b0;
      end
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_frame_tick <= 1'b0;
    end
  end

  generate
    if (BLANK == 0) begin : g_noblank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK));
    end
  endgenerate

  assign w_onehot     = 4'b0001 << r_idx;
  assign o_anodes     = w_blank ? 4'b1111 : ~(w_onehot & r_en_sh);
  assign o_value      = r_val_sh[{r_idx, 1'b0} +: 2];
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: frame-level reference model feeding a scoreboard queue, plus
// directed hand-computed checks. Two instances run side by side (BLANK=2 and BLANK=0).
module tb_display_scan;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] den;

  logic [1:0] val2, val0;
  logic [3:0] an2, an0;
  logic       tick2, tick0;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = clk_en ? ~clk : 1'b0;

  display_scan #(.DIV(DIV), .BLANK(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits_in(din), .i_digit_en(den),
    .o_value(val2), .o_anodes(an2), .o_frame_tick(tick2)
  );

  display_scan #(.DIV(DIV), .BLANK(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits_in(din), .i_digit_en(den),
    .o_value(val0), .o_anodes(an0), .o_frame_tick(tick0)
  );

  typedef struct packed {
    logic [3:0] an2;
    logic [3:0] an0;
    logic [1:0] val;
    logic       tick;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: frame-relative time plus the snapshot taken at each wrap.
  int         m_t;
  logic [7:0] m_val;
  logic [3:0] m_en;
  logic       m_tick;

  always @(posedge clk or negedge rst_n) begin : model
    int   slot, c;
    exp_t e;
    if (!rst_n) begin
      m_t = 0; m_val = 8'd0; m_en = 4'd0; m_tick = 1'b0;
      q.delete();
    end else begin
      if (m_t == 4*DIV-1) begin
        m_t = 0; m_val = din; m_en = den; m_tick = 1'b1;
      end else begin
        m_t = m_t + 1; m_tick = 1'b0;
      end
      slot   = m_t / DIV;
      c      = m_t % DIV;
      e.val  = m_val[2*slot +: 2];
      e.an0  = ~((4'b0001 << slot) & m_en);
      e.an2  = (c < 2) ? 4'b1111 : e.an0;
      e.tick = m_tick;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_anodes_b2", {4'd0, an2},  {4'd0, e.an2});
      chk("sb_value_b2",  {6'd0, val2}, {6'd0, e.val});
      chk("sb_tick_b2",   {7'd0, tick2}, {7'd0, e.tick});
      chk("sb_anodes_b0", {4'd0, an0},  {4'd0, e.an0});
      chk("sb_value_b0",  {6'd0, val0}, {6'd0, e.val});
      chk("sb_tick_b0",   {7'd0, tick0}, {7'd0, e.tick});
    end
  end

  task automatic at_cycle(input int n);
    int budget = 5000;
    @(negedge clk);
    while (cyc != n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (cyc != n) begin
      total++; bad++;
      $display("FAIL wait_cycle: reached %0d required %0d", cyc, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an2"},  {4'd0, an2},   8'h0f);
    chk({tag, "_val2"}, {6'd0, val2},  8'h00);
    chk({tag, "_tk2"},  {7'd0, tick2}, 8'h00);
    chk({tag, "_an0"},  {4'd0, an0},   8'h0f);
    chk({tag, "_tk0"},  {7'd0, tick0}, 8'h00);
  endtask

  initial begin : stim
    int lit_blank, ticks;
    rst_n = 1'b0;
    din   = 8'b11_10_01_00;
    den   = 4'b1111;

    #20;
    chk_reset_outputs("reset_noclk");

    clk_en = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;

    // first frame after reset is dark, then captured data appears
    at_cycle(20); chk("dark_c20",  {4'd0, an2}, 8'h0f);
    at_cycle(31); chk("dark_c31",  {4'd0, an2}, 8'h0f);
                  chk("tick_c31",  {7'd0, tick2}, 8'h00);
    at_cycle(32); chk("tick_c32",  {7'd0, tick2}, 8'h01);
                  chk("blank_c32", {4'd0, an2}, 8'h0f);
    at_cycle(33); chk("tick_c33",  {7'd0, tick2}, 8'h00);
                  chk("blank_c33", {4'd0, an2}, 8'h0f);
    at_cycle(34); chk("an_c34",    {4'd0, an2}, 8'h0e);
                  chk("val_c34",   {6'd0, val2}, 8'h00);
    at_cycle(42); chk("an_c42",    {4'd0, an2}, 8'h0d);
                  chk("val_c42",   {6'd0, val2}, 8'h01);
    at_cycle(45); din = 8'h00;
    at_cycle(50); chk("an_c50",    {4'd0, an2}, 8'h0b);
                  chk("val_c50",   {6'd0, val2}, 8'h02);
    at_cycle(58); chk("an_c58",    {4'd0, an2}, 8'h07);
                  chk("val_c58",   {6'd0, val2}, 8'h03);
    at_cycle(63); chk("an_c63",    {4'd0, an2}, 8'h07);
    at_cycle(64); chk("tick_c64",  {7'd0, tick2}, 8'h01);
                  chk("an0_c64",   {4'd0, an0}, 8'h0e);
    at_cycle(66); chk("val_c66",   {6'd0, val2}, 8'h00);
    at_cycle(74); chk("val_c74",   {6'd0, val2}, 8'h00);

    // enable mask 0101 captured at the 95->96 boundary
    at_cycle(80);  den = 4'b0101;
    at_cycle(98);  chk("mask_s0",  {4'd0, an2}, 8'h0e);
    at_cycle(106); chk("mask_s1",  {4'd0, an2}, 8'h0f);
                   chk("mask0_s1", {4'd0, an0}, 8'h0f);
    at_cycle(114); chk("mask_s2",  {4'd0, an2}, 8'h0b);
    at_cycle(117);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_mid");
    repeat (3) @(posedge clk);
    chk_reset_outputs("reset_held");
    @(negedge clk); #2 rst_n = 1'b1;

    at_cycle(1);  chk("rst_dark_c1",  {4'd0, an2}, 8'h0f);
    at_cycle(31); chk("rst_tick_c31", {7'd0, tick2}, 8'h00);
    at_cycle(32); chk("rst_tick_c32", {7'd0, tick2}, 8'h01);
    at_cycle(34); chk("rst_an_c34",   {4'd0, an2}, 8'h0e);

    // BLANK=0 steady state with every digit enabled
    at_cycle(40); den = 4'b1111; din = 8'b01_11_00_10;
    at_cycle(64);
    lit_blank = 0; ticks = 0;
    for (int i = 0; i < 64; i++) begin
      if (an0 == 4'b1111) lit_blank++;
      if (tick0) ticks++;
      @(negedge clk);
    end
    chk("b0_never_dark", lit_blank[7:0], 8'd0);
    chk("b0_tick_count", ticks[7:0], 8'd2);

    // long run: random inputs changed at random cycles
    for (int i = 0; i < 100*4*DIV; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) din = 8'($urandom);
      if ($urandom_range(23) == 0) den = 4'($urandom);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display. It sits directly upstream of the 2-bit digit decoder: each digit slot drives one active-low anode and presents that digit's 2-bit value to the decoder, which converts it to active-low segments. Input values and enables are captured once per frame so that every digit in a frame is drawn from the same snapshot. A blanking window at the start of each slot prevents ghosting between digits.

## Interface
- `DIV`, 50000: clock cycles per digit slot; 1 kHz slot rate at 50 MHz. Must be ≥ 2.
- `BLANK`, 1000: cycles at the start of each slot with all anodes off. Legal range 0 ≤ BLANK < DIV.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits_in`  in  8  four 2-bit digit values; digit k is at [2k+1:2k], so digit 0 is [1:0].
- `digit_en`  in  4  per-digit enable; bit k = 1 lights digit k.
- `value`  out  2  value of the current digit, fed to the decoder.
- `anodes`  out  4  active-low anode enables; bit k drives digit k.
- `frame_tick`  out  1  one-cycle pulse marking the first cycle of each new frame.

One clock; reset is asynchronous and active-low.

## Operation
- **State registers:**
  - `cnt`, 0..DIV-1, width clog2(DIV).
  - `idx`, 0..3, the current digit.
  - `val_sh[7:0]` and `en_sh[3:0]`, the frame snapshot.
  - `frame_tick` register.
- **Each edge:**
  - If `cnt` < DIV-1: `cnt` increments and nothing else changes.
  - If `cnt` == DIV-1: `cnt` returns to 0 and `idx` advances 0→1→2→3→0.
- **Frame boundary** (edge where `cnt` == DIV-1 and `idx` == 3):
  - `val_sh` <= `digits_in` and `en_sh` <= `digit_en`.
  - `frame_tick` <= 1.
  - On every other edge, `frame_tick` <= 0.
- **`value`:** `val_sh[2*idx+1 : 2*idx]`.
- **`anodes`:**
  - 4'b1111 while `cnt` < BLANK.
  - Otherwise ~(onehot(`idx`) & `en_sh`).
- **Output decode:** outputs are decoded only from internal registers. There is no combinational path from any input to any output.
- **Input timing:** changes to `digits_in` or `digit_en` mid-frame have no visible effect until the next frame boundary.
- **Reset state:** `cnt`=0, `idx`=0, `val_sh`=0, `en_sh`=0, `frame_tick`=0. The resulting outputs are:
  - `anodes`=4'b1111
  - `value`=2'b00
  - `frame_tick`=0
- **First frame:** the first frame after reset is dark, because `en_sh`=0. Real data appears from the second frame onward.
- **Reset mid-operation:** asserting `rst_n` low forces the reset state immediately, without waiting for a clock edge. Scanning resumes at `idx`=0, `cnt`=0 on the first edge after release.
- **BLANK = 0:** no blanking window. An enabled digit is lit for the full slot.

## Timing
- Frame length: 4·DIV cycles. Slot k occupies frame-relative cycles k·DIV .. k·DIV+DIV-1.
- Lit time per enabled digit: DIV-BLANK cycles per frame.
- Capture latency:
  - Data present at the frame-boundary edge is displayed starting at digit 0 of the next frame: 1 cycle after capture, blanking included.
  - Worst-case latency from an input change to display is 4·DIV+1 cycles.
- `frame_tick`:
  - High exactly during the (`idx`=0, `cnt`=0) cycle that follows each wrap.
  - Never high in the first post-reset cycle.
- `value` changes only on slot boundaries, while anodes are blanked (when BLANK ≥ 1).

## Test plan
All scenarios use DIV=8, BLANK=2 unless stated otherwise.
- **Async reset:** hold `rst_n`=0 with no clock running. Required: `anodes`=1111, `value`=00, `frame_tick`=0. Then pulse `rst_n` low mid-slot of digit 2. Required: outputs return to reset values immediately, and digit 0 restarts from `cnt`=0 after release.
- **First capture:** `digits_in`=8'b11_10_01_00, `digit_en`=1111.
  - Cycles 0–31 after reset: `anodes`=1111 throughout.
  - Cycle 32: `frame_tick`=1 for exactly one cycle.
  - Cycles 32–33: `anodes`=1111.
  - Cycles 34–39: `anodes`=1110, `value`=00.
  - Cycles 42–47: `anodes`=1101, `value`=01.
  - Cycles 50–55: `anodes`=1011, `value`=10.
  - Cycles 58–63: `anodes`=0111, `value`=11.
- **Mid-frame change:** change `digits_in` to 8'h00 at cycle 45. Required: `value`=10 at cycle 50 and 11 at cycle 58 (old snapshot). `value`=00 in all slots of the frame starting at cycle 64.
- **Enable mask:** `digit_en`=0101 captured at a frame boundary. Required: in that frame, `anodes` stays 1111 during slots 1 and 3; slots 0 and 2 show 1110 and 1011 after blanking.
- **No blanking (BLANK=0):** `digit_en`=1111 in steady state. Required: `anodes` is never 1111. Each slot is lit for all 8 cycles, and one `frame_tick` occurs every 32 cycles.
- **Long run:** 100 frames with random `digits_in`/`digit_en` changed only at random cycles. Required: a scoreboard of per-slot (`anodes`, `value`) against the snapshot taken at each `frame_tick` matches on every cycle.
